// File: rtl/alu_seq.sv
// alu_seq: execution-stage ALU with valid/ready handshakes on both sides.
// Add/logic/shift ops finish in one cycle; MUL, DIV and REM iterate one
// operand bit per cycle. Results are zero-extended from the active width
// and come with an x86-style EFLAGS image.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a request, in_ready high
// ST_MUL  | shift-add multiply, one multiplier bit per cycle
// ST_DIV  | restoring divide, one quotient bit per cycle
// ST_DONE | result registered, out_valid high until out_ready
module alu_seq #(
    parameter int W      = 64,
    parameter int CF_POS = 0,
    parameter int PF_POS = 2,
    parameter int AF_POS = 4,
    parameter int ZF_POS = 6,
    parameter int SF_POS = 7,
    parameter int OF_POS = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_op,
    input  logic [1:0]   in_bmd,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_t,
    input  logic [W-1:0] in_eflags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_d,
    output logic [W-1:0] out_eflags,
    output logic         out_eflags_update,
    output logic         out_div_zero
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;
    localparam logic [3:0] OP_REM = 4'd9;

    // Guard bit just below the integer part of a right-shift result.
    localparam logic [W-1:0] TOP_BIT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    // Active operand width in bits; a 64-bit request on a 32-bit build runs at 32.
    function automatic logic [6:0] width_of(input logic [1:0] bmd);
        logic [6:0] n;
        case (bmd)
            2'd0:    n = 7'd8;
            2'd1:    n = 7'd16;
            2'd2:    n = 7'd32;
            default: n = (W == 32) ? 7'd32 : 7'd64;
        endcase
        return n;
    endfunction

    // Low-n-bit mask; a shift by the full width yields zero so n == W gives all ones.
    function automatic logic [W-1:0] mask_of(input logic [6:0] n);
        return ~({W{1'b1}} << n);
    endfunction

    // Flag image for ops that update EFLAGS; d is already masked to the width m.
    function automatic logic [W-1:0] flags_of(input logic [W-1:0] base,
                                              input logic [W-1:0] d,
                                              input logic [W-1:0] m,
                                              input logic         cf,
                                              input logic         ovf);
        logic [W-1:0] f;
        f         = base;
        f[CF_POS] = cf;
        f[PF_POS] = ~^d[7:0];
        f[AF_POS] = 1'b0;
        f[ZF_POS] = (d == '0);
        f[SF_POS] = |(d & m & ~(m >> 1));
        f[OF_POS] = ovf;
        return f;
    endfunction

    state_t         state_q;
    logic [3:0]     op_q;
    logic [W-1:0]   m_q;
    logic [W-1:0]   eflags_q;
    logic [5:0]     cnt_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] prod_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   div_q;
    logic           out_valid_q;
    logic [W-1:0]   out_d_q;
    logic [W-1:0]   out_eflags_q;
    logic           out_upd_q;
    logic           out_dz_q;

    logic [6:0]            n_in;
    logic [W-1:0]          m_in;
    logic [W-1:0]          msb_in;
    logic [W-1:0]          s_m;
    logic [W-1:0]          t_m;
    logic [5:0]            shamt;
    logic [W:0]            sum;
    logic [W-1:0]          s_sx;
    logic [2*W-1:0]        bitn_in;
    logic [2*W-1:0]        sll_w;
    logic [2*W-1:0]        srl_w;
    logic signed [2*W-1:0] sra_w;
    logic                  s_neg;
    logic                  t_neg;
    logic                  r_neg;
    logic [W-1:0]          sc_res;
    logic [W-1:0]          sc_eflags;
    logic                  sc_cf;
    logic                  sc_of;
    logic                  sc_upd;
    logic                  sc_dz;

    logic [2*W-1:0] prod_d;
    logic [W-1:0]   mul_res;
    logic           mul_hi;
    logic [W-1:0]   mul_eflags;
    logic [W:0]     div_sh;
    logic           div_ge;
    logic [W-1:0]   rem_d;
    logic [W-1:0]   quo_d;
    logic [W-1:0]   div_res;

    assign in_ready          = (state_q == ST_IDLE) && !rst;
    assign out_valid         = out_valid_q;
    assign out_d             = out_d_q;
    assign out_eflags        = out_eflags_q;
    assign out_eflags_update = out_upd_q;
    assign out_div_zero      = out_dz_q;

    // Single-cycle result computed straight from the request operands.
    always_comb begin
        n_in    = width_of(in_bmd);
        m_in    = mask_of(n_in);
        msb_in  = m_in & ~(m_in >> 1);
        s_m     = in_s & m_in;
        t_m     = in_t & m_in;
        shamt   = (n_in == 7'd64) ? in_t[5:0] : {1'b0, in_t[4:0]};
        sum     = {1'b0, s_m} + {1'b0, t_m};
        s_neg   = |(s_m & msb_in);
        t_neg   = |(t_m & msb_in);
        s_sx    = s_neg ? (s_m | ~m_in) : s_m;
        bitn_in = {{W{1'b0}}, m_in} + {{(2*W-1){1'b0}}, 1'b1};
        sll_w   = {{W{1'b0}}, s_m} << shamt;
        srl_w   = {s_m, {W{1'b0}}} >> shamt;
        sra_w   = $signed({s_sx, {W{1'b0}}}) >>> shamt;
        sc_res  = '0;
        sc_cf   = 1'b0;
        sc_of   = 1'b0;
        sc_upd  = 1'b0;
        sc_dz   = 1'b0;
        r_neg   = 1'b0;
        case (in_op)
            OP_ADD: begin
                sc_res = sum[W-1:0] & m_in;
                r_neg  = |(sc_res & msb_in);
                sc_cf  = |(sum & ~{1'b0, m_in});
                sc_of  = (s_neg == t_neg) && (r_neg != s_neg);
                sc_upd = 1'b1;
            end
            OP_AND: begin
                sc_res = s_m & t_m;
                sc_upd = 1'b1;
            end
            OP_OR: begin
                sc_res = s_m | t_m;
                sc_upd = 1'b1;
            end
            OP_XOR: begin
                sc_res = s_m ^ t_m;
                sc_upd = 1'b1;
            end
            OP_SLL, OP_SRL, OP_SRA: begin
                if (shamt == '0) begin
                    sc_res = s_m;
                end else begin
                    sc_upd = 1'b1;
                    if (in_op == OP_SLL) begin
                        sc_res = sll_w[W-1:0] & m_in;
                        sc_cf  = |(sll_w & bitn_in);
                    end else if (in_op == OP_SRL) begin
                        sc_res = srl_w[2*W-1:W];
                        sc_cf  = |(srl_w[W-1:0] & TOP_BIT);
                    end else begin
                        sc_res = sra_w[2*W-1:W] & m_in;
                        sc_cf  = |(sra_w[W-1:0] & TOP_BIT);
                    end
                end
            end
            // Only the zero-divisor case finishes here; nonzero divisors iterate.
            OP_DIV, OP_REM: begin
                sc_res = m_in;
                sc_dz  = 1'b1;
            end
            default: begin
                sc_res = '0;
            end
        endcase
        sc_eflags = sc_upd ? flags_of(in_eflags, sc_res, m_in, sc_cf, sc_of) : in_eflags;
    end

    // One iteration step of the multiplier and of the divider.
    always_comb begin
        prod_d     = prod_q + (mplier_q[0] ? mcand_q : '0);
        mul_res    = prod_d[W-1:0] & m_q;
        mul_hi     = |(prod_d & ~{{W{1'b0}}, m_q});
        mul_eflags = flags_of(eflags_q, mul_res, m_q, mul_hi, mul_hi);
        div_sh     = {rem_q, quo_q[W-1]};
        div_ge     = (div_sh >= {1'b0, div_q});
        rem_d      = div_ge ? (div_sh[W-1:0] - div_q) : div_sh[W-1:0];
        quo_d      = {quo_q[W-2:0], div_ge};
        div_res    = ((op_q == OP_DIV) ? quo_d : rem_d) & m_q;
    end

    // Sequencer: accept, iterate, hold the result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            m_q          <= '0;
            eflags_q     <= '0;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            prod_q       <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            div_q        <= '0;
            out_valid_q  <= 1'b0;
            out_d_q      <= '0;
            out_eflags_q <= '0;
            out_upd_q    <= 1'b0;
            out_dz_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        m_q      <= m_in;
                        eflags_q <= in_eflags;
                        cnt_q    <= 6'(n_in - 7'd1);
                        if (in_op == OP_MUL) begin
                            mcand_q  <= {{W{1'b0}}, s_m};
                            mplier_q <= t_m;
                            prod_q   <= '0;
                            state_q  <= ST_MUL;
                        end else if ((in_op == OP_DIV || in_op == OP_REM) && t_m != '0) begin
                            // Align the dividend MSB to the top so bits shift out MSB first.
                            quo_q   <= s_m << (7'(W) - n_in);
                            rem_q   <= '0;
                            div_q   <= t_m;
                            state_q <= ST_DIV;
                        end else begin
                            out_valid_q  <= 1'b1;
                            out_d_q      <= sc_res;
                            out_eflags_q <= sc_eflags;
                            out_upd_q    <= sc_upd;
                            out_dz_q     <= sc_dz;
                            state_q      <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 6'd1;
                    if (cnt_q == '0) begin
                        out_valid_q  <= 1'b1;
                        out_d_q      <= mul_res;
                        out_eflags_q <= mul_eflags;
                        out_upd_q    <= 1'b1;
                        out_dz_q     <= 1'b0;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == '0) begin
                        out_valid_q  <= 1'b1;
                        out_d_q      <= div_res;
                        out_eflags_q <= eflags_q;
                        out_upd_q    <= 1'b0;
                        out_dz_q     <= 1'b0;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic
// reference model built from plain integer operations.
module tb_alu_seq;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [1:0]   in_bmd;
    logic [W-1:0] in_s;
    logic [W-1:0] in_t;
    logic [W-1:0] in_eflags;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_d;
    logic [W-1:0] out_eflags;
    logic         out_eflags_update;
    logic         out_div_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.W(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_op             (in_op),
        .in_bmd            (in_bmd),
        .in_s              (in_s),
        .in_t              (in_t),
        .in_eflags         (in_eflags),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_d             (out_d),
        .out_eflags        (out_eflags),
        .out_eflags_update (out_eflags_update),
        .out_div_zero      (out_div_zero)
    );

    typedef struct {
        logic [63:0] d;
        logic [63:0] ef;
        logic        upd;
        logic        dz;
        int          lat;
    } res_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: N-bit unsigned/signed integer arithmetic, shifts as repeated single steps.
    function automatic res_t model(input int op, input int bmd, input logic [63:0] s_raw,
                                   input logic [63:0] t_raw, input logic [63:0] ef);
        res_t r;
        int n;
        int cnt;
        logic [63:0] mask;
        logic [127:0] s;
        logic [127:0] t;
        logic [127:0] x;
        logic signed [127:0] sv;
        logic signed [127:0] tv;
        logic signed [127:0] lim;
        logic cf;
        logic ovf;
        logic fl;
        n = 8 << bmd;
        mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        s = {64'd0, s_raw & mask};
        t = {64'd0, t_raw & mask};
        r.d = '0; r.ef = ef; r.upd = 1'b0; r.dz = 1'b0; r.lat = 1;
        cf = 1'b0; ovf = 1'b0; fl = 1'b0;
        case (op)
            0: begin
                x = s + t;
                r.d = x[63:0] & mask;
                cf = ((x >> n) != 0);
                sv = $signed(s);
                if (s[n-1]) sv = sv - (128'sd1 <<< n);
                tv = $signed(t);
                if (t[n-1]) tv = tv - (128'sd1 <<< n);
                lim = 128'sd1 <<< (n - 1);
                ovf = (sv + tv >= lim) || (sv + tv < -lim);
                fl = 1'b1;
            end
            1: begin r.d = s[63:0] & t[63:0]; fl = 1'b1; end
            2: begin r.d = s[63:0] | t[63:0]; fl = 1'b1; end
            3: begin r.d = s[63:0] ^ t[63:0]; fl = 1'b1; end
            4, 5, 6: begin
                cnt = int'(t_raw & ((n == 64) ? 64'd63 : 64'd31));
                x = s;
                if (cnt == 0) begin
                    r.d = s[63:0];
                end else begin
                    for (int i = 0; i < cnt; i++) begin
                        if (op == 4) begin
                            cf = x[n-1];
                            x = (x << 1) & {64'd0, mask};
                        end else if (op == 5) begin
                            cf = x[0];
                            x = x >> 1;
                        end else begin
                            cf = x[0];
                            x = (x >> 1) | (s[n-1] ? (128'd1 << (n - 1)) : 128'd0);
                        end
                    end
                    r.d = x[63:0];
                    fl = 1'b1;
                end
            end
            7: begin
                x = s * t;
                r.d = x[63:0] & mask;
                cf = ((x >> n) != 0);
                ovf = cf;
                fl = 1'b1;
                r.lat = n + 1;
            end
            8, 9: begin
                if (t == 0) begin
                    r.d = mask;
                    r.dz = 1'b1;
                end else begin
                    x = (op == 8) ? (s / t) : (s % t);
                    r.d = x[63:0];
                    r.lat = n + 1;
                end
            end
            default: r.d = '0;
        endcase
        if (fl) begin
            r.upd = 1'b1;
            r.ef[0] = cf;
            r.ef[2] = ($countones(r.d[7:0]) % 2 == 0);
            r.ef[4] = 1'b0;
            r.ef[6] = (r.d == 0);
            r.ef[7] = r.d[n-1];
            r.ef[11] = ovf;
        end
        return r;
    endfunction

    // Issue one request from IDLE and wait (bounded) for its result.
    task automatic do_op(input string tag, input int op, input int bmd, input logic [63:0] s,
                         input logic [63:0] t, input logic [63:0] ef, output res_t e, output int lat);
        e = model(op, bmd, s, t, ef);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = 4'(op); in_bmd = 2'(bmd);
        in_s = s; in_t = t; in_eflags = ef;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(e.lat));
        check({tag, ".d"}, out_d, e.d);
        check({tag, ".eflags"}, out_eflags, e.ef);
        check({tag, ".update"}, 64'(out_eflags_update), 64'(e.upd));
        check({tag, ".div_zero"}, 64'(out_div_zero), 64'(e.dz));
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".retired"}, 64'(out_valid), 64'd0);
        check({tag, ".ready_again"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t e;
        int lat;
        int seen;
        int op;
        int bmd;
        logic [63:0] s;
        logic [63:0] t;
        logic [63:0] ef;

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_bmd = '0;
        in_s = '0; in_t = '0; in_eflags = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_d", out_d, 64'd0);
        check("rst.out_eflags", out_eflags, 64'd0);
        check("rst.update", 64'(out_eflags_update), 64'd0);
        check("rst.div_zero", 64'(out_div_zero), 64'd0);
        check("rst.in_ready_low", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst.in_ready_high", 64'(in_ready), 64'd1);

        // Reset lands in the middle of a 64-bit multiply.
        in_valid = 1'b1; in_op = 4'd7; in_bmd = 2'd3; in_s = 64'd7; in_t = 64'd9; in_eflags = '0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mulrst.in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check("mulrst.no_result", 64'(seen), 64'd0);
        do_op("mulrst.add", 0, 3, 64'd1, 64'd1, 64'd0, e, lat);
        check("mulrst.add_is_2", out_d, 64'd2);
        retire("mulrst");

        do_op("add_wrap", 0, 0, 64'hFF, 64'h01, 64'h0, e, lat);
        check("add_wrap.d0", out_d, 64'h0);
        check("add_wrap.cf", 64'(out_eflags[0]), 64'd1);
        check("add_wrap.zf", 64'(out_eflags[6]), 64'd1);
        check("add_wrap.pf", 64'(out_eflags[2]), 64'd1);
        check("add_wrap.of", 64'(out_eflags[11]), 64'd0);
        check("add_wrap.lat1", 64'(lat), 64'd1);
        retire("add_wrap");

        do_op("mul_ovf", 7, 1, 64'h0100, 64'h0100, 64'hA5A5_0000_0000_0200, e, lat);
        check("mul_ovf.cf_of", {62'd0, out_eflags[11], out_eflags[0]}, 64'd3);
        check("mul_ovf.lat17", 64'(lat), 64'd17);
        retire("mul_ovf");

        do_op("div", 8, 2, 64'd100, 64'd7, 64'h0000_0000_0000_0893, e, lat);
        check("div.q14", out_d, 64'd14);
        check("div.lat33", 64'(lat), 64'd33);
        retire("div");
        do_op("rem", 9, 2, 64'd100, 64'd7, 64'hFFFF_0000_0000_0000, e, lat);
        check("rem.r2", out_d, 64'd2);
        retire("rem");
        do_op("div0", 8, 2, 64'd100, 64'd0, 64'h0000_0000_0000_00C5, e, lat);
        check("div0.ones", out_d, 64'hFFFF_FFFF);
        check("div0.flag", 64'(out_div_zero), 64'd1);
        retire("div0");

        do_op("sra", 6, 0, 64'h80, 64'd3, 64'h0, e, lat);
        check("sra.f0", out_d, 64'hF0);
        check("sra.cf_sf", {62'd0, out_eflags[7], out_eflags[0]}, 64'd2);
        retire("sra");
        do_op("srl", 5, 0, 64'h81, 64'd1, 64'h0, e, lat);
        check("srl.40", out_d, 64'h40);
        check("srl.cf", 64'(out_eflags[0]), 64'd1);
        retire("srl");
        do_op("sll32", 4, 0, 64'h5A, 64'd32, 64'h0000_0000_0000_0801, e, lat);
        check("sll32.pass", out_d, 64'h5A);
        check("sll32.noupd", 64'(out_eflags_update), 64'd0);
        retire("sll32");

        // Backpressure: the result must hold while the consumer stalls.
        out_ready = 1'b0;
        do_op("bp", 7, 2, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, e, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.valid", 64'(out_valid), 64'd1);
            check("bp.d", out_d, e.d);
            check("bp.eflags", out_eflags, e.ef);
            check("bp.in_ready", 64'(in_ready), 64'd0);
        end
        retire("bp");

        for (int k = 0; k < 150; k++) begin
            op = int'($urandom_range(0, 15));
            bmd = int'($urandom_range(0, 3));
            s = {$urandom, $urandom};
            t = {$urandom, $urandom};
            ef = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) t = 64'($urandom_range(0, 40));
            do_op($sformatf("rnd%0d_op%0d_b%0d", k, op, bmd), op, bmd, s, t, ef, e, lat);
            retire("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
